uart_tx_serializer: RTL and testbench

- Transmit half of the UART block. It takes a parallel byte with a valid strobe and drives one asynchronous serial frame on TX_OUT: start bit, DATA_WIDTH data bits LSB first, optional parity bit, one stop bit.
- The bit period is Prescale clk cycles, generated internally, so the serializer runs on the same system clock as the receive path.
- It is the far-end partner of the RX edge/bit counter.

---
 rtl/uart_tx_serializer_pkg.sv | 22 ++
 rtl/uart_tx_bit_timer.sv | 35 +++
 rtl/uart_tx_serializer.sv | 117 +++++++++++
 tb/tb_uart_tx_serializer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_serializer_pkg.sv
// Shared UART definitions: transmit FSM encoding, line levels and parity selectors.
// The receive path imports this package as well.
package uart_tx_serializer_pkg;

  localparam int UART_DATA_WIDTH = 8;

  localparam logic UART_IDLE_LVL  = 1'b1;
  localparam logic UART_START_LVL = 1'b0;
  localparam logic UART_STOP_LVL  = 1'b1;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_t;

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Bit-period timer: holds the prescale captured at frame accept and pulses
// bit_done on the last clk of every serial bit.
module uart_tx_bit_timer #(
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load,
  input  logic                      clear,
  input  logic                      run,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic                      bit_done
);

  logic [PRESCALE_WIDTH-1:0] period_m1;
  logic [PRESCALE_WIDTH-1:0] count;

  assign bit_done = run && (count == period_m1);

  // A prescale of zero behaves like one: every bit lasts a single clk.
  always_ff @(posedge clk) begin
    if (rst) begin
      period_m1 <= '0;
      count     <= '0;
    end else if (load) begin
      period_m1 <= (prescale == '0) ? '0 : prescale - PRESCALE_WIDTH'(1);
      count     <= '0;
    end else if (clear || bit_done || !run) begin
      count <= '0;
    end else begin
      count <= count + PRESCALE_WIDTH'(1);
    end
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmitter: serializes a byte as start, LSB-first data, optional
// parity and one stop bit, each bit lasting the captured prescale count.
module uart_tx_serializer
  import uart_tx_serializer_pkg::*;
#(
  parameter int DATA_WIDTH     = UART_DATA_WIDTH,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_WIDTH-1:0]     P_DATA,
  input  logic                      Data_Valid,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  input  logic [PRESCALE_WIDTH-1:0] Prescale,
  output logic                      TX_OUT,
  output logic                      Busy
);

  localparam int CNT_W = $clog2(DATA_WIDTH);

  uart_tx_state_t state, state_next;

  logic [DATA_WIDTH-1:0] shift_reg, shift_next;
  logic [CNT_W-1:0]      bit_cnt, bit_cnt_next;
  logic                  par_en_q, par_en_next;
  logic                  par_bit_q, par_bit_next;
  logic                  tx_next, busy_next;
  logic                  accept, bit_done;

  uart_tx_bit_timer #(
    .PRESCALE_WIDTH(PRESCALE_WIDTH)
  ) u_bit_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .clear    (state_next != state),
    .run      (state != IDLE),
    .prescale (Prescale),
    .bit_done (bit_done)
  );

  always_comb begin
    state_next   = state;
    shift_next   = shift_reg;
    bit_cnt_next = bit_cnt;
    par_en_next  = par_en_q;
    par_bit_next = par_bit_q;
    accept       = 1'b0;

    case (state)
      IDLE: begin
        if (Data_Valid) begin
          accept       = 1'b1;
          state_next   = START;
          shift_next   = P_DATA;
          bit_cnt_next = '0;
          par_en_next  = PAR_EN;
          par_bit_next = (^P_DATA) ^ (PAR_TYP == PAR_ODD);
        end
      end
      START: begin
        if (bit_done) state_next = DATA;
      end
      DATA: begin
        if (bit_done) begin
          shift_next = shift_reg >> 1;
          if (bit_cnt == CNT_W'(DATA_WIDTH - 1)) begin
            bit_cnt_next = '0;
            state_next   = par_en_q ? PARITY : STOP;
          end else begin
            bit_cnt_next = bit_cnt + CNT_W'(1);
          end
        end
      end
      PARITY: begin
        if (bit_done) state_next = STOP;
      end
      STOP: begin
        if (bit_done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // Outputs are decoded from the upcoming state so they can be registered
    // without lagging the FSM by a cycle.
    case (state_next)
      START:   tx_next = UART_START_LVL;
      DATA:    tx_next = shift_next[0];
      PARITY:  tx_next = par_bit_next;
      STOP:    tx_next = UART_STOP_LVL;
      default: tx_next = UART_IDLE_LVL;
    endcase
    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      TX_OUT    <= UART_IDLE_LVL;
      Busy      <= 1'b0;
    end else begin
      state     <= state_next;
      shift_reg <= shift_next;
      bit_cnt   <= bit_cnt_next;
      par_en_q  <= par_en_next;
      par_bit_q <= par_bit_next;
      TX_OUT    <= tx_next;
      Busy      <= busy_next;
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer: per-cycle expected line/busy
// values are queued at each accept and popped on every falling clock edge.
module tb_uart_tx_serializer;

  typedef struct {
    logic [7:0] data;
    logic       par_en;
    logic       par_typ;
    logic [5:0] prescale;
    logic       exp_par;
    int         exp_len;
  } vec_t;

  typedef struct {
    logic tx;
    logic busy;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] P_DATA;
  logic       Data_Valid;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [5:0] Prescale;
  logic       TX_OUT;
  logic       Busy;

  exp_t sbQueue[$];
  int   compared    = 0;
  int   mismatched  = 0;
  int   busyRun     = 0;
  int   lastBusyLen = 0;

  vec_t vecs[7];
  vec_t v55, vAA;

  uart_tx_serializer #(
    .DATA_WIDTH(8),
    .PRESCALE_WIDTH(6)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .Prescale   (Prescale),
    .TX_OUT     (TX_OUT),
    .Busy       (Busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Scoreboard consumer: one expected sample per clk while entries are queued.
  always @(negedge clk) begin
    exp_t e;
    if (sbQueue.size() > 0) begin
      e = sbQueue.pop_front();
      checkOutput("tx_out", {31'd0, TX_OUT}, {31'd0, e.tx});
      checkOutput("busy", {31'd0, Busy}, {31'd0, e.busy});
    end
  end

  always @(negedge clk) begin
    if (Busy === 1'b1) begin
      busyRun++;
    end else begin
      if (busyRun > 0) lastBusyLen = busyRun;
      busyRun = 0;
    end
  end

  task automatic pushFrame(input vec_t v, input int tail);
    int   p;
    logic bits[$];
    p = (v.prescale == 6'd0) ? 1 : int'(v.prescale);
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(v.data[i]);
    if (v.par_en) bits.push_back(v.exp_par);
    bits.push_back(1'b1);
    foreach (bits[b]) begin
      for (int k = 0; k < p; k++) sbQueue.push_back(exp_t'{bits[b], 1'b1});
    end
    for (int k = 0; k < tail; k++) sbQueue.push_back(exp_t'{1'b1, 1'b0});
  endtask

  task automatic applyStimulus(input vec_t v, input int tail);
    @(posedge clk);
    #1;
    P_DATA     = v.data;
    PAR_EN     = v.par_en;
    PAR_TYP    = v.par_typ;
    Prescale   = v.prescale;
    Data_Valid = 1'b1;
    @(posedge clk);
    #1;
    Data_Valid = 1'b0;
    pushFrame(v, tail);
  endtask

  task automatic waitDrain(input string name, input int budget);
    int n = 0;
    while (sbQueue.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (sbQueue.size() != 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL %s: timeout with %0d samples pending, expected 0", name, sbQueue.size());
      sbQueue.delete();
    end
  endtask

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 1'b0, 6'd8,  1'b0, 88};
    vecs[1] = '{8'h3C, 1'b0, 1'b0, 6'd16, 1'b0, 160};
    vecs[2] = '{8'h01, 1'b1, 1'b1, 6'd1,  1'b0, 11};
    vecs[3] = '{8'h01, 1'b1, 1'b1, 6'd0,  1'b0, 11};
    vecs[4] = '{8'h80, 1'b1, 1'b0, 6'd3,  1'b1, 33};
    vecs[5] = '{8'hFF, 1'b1, 1'b1, 6'd2,  1'b1, 22};
    vecs[6] = '{8'h00, 1'b0, 1'b0, 6'd5,  1'b0, 50};
    v55     = '{8'h55, 1'b0, 1'b0, 6'd4,  1'b0, 40};
    vAA     = '{8'hAA, 1'b0, 1'b0, 6'd4,  1'b0, 40};

    rst        = 1'b1;
    P_DATA     = 8'h00;
    Data_Valid = 1'b0;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;
    Prescale   = 6'd1;
    repeat (3) @(posedge clk);
    #1;
    sbQueue.push_back(exp_t'{1'b1, 1'b0});
    sbQueue.push_back(exp_t'{1'b1, 1'b0});
    waitDrain("reset_state", 10);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      lastBusyLen = -1;
      applyStimulus(vecs[i], 2);
      waitDrain("frame_drain", 400);
      checkOutput("busy_len", lastBusyLen, vecs[i].exp_len);
    end

    // Request during the data bits of a frame must be dropped.
    lastBusyLen = -1;
    applyStimulus(vecs[0], 6);
    repeat (30) @(negedge clk);
    P_DATA     = 8'hFF;
    Data_Valid = 1'b1;
    @(negedge clk);
    Data_Valid = 1'b0;
    waitDrain("dropped_drain", 200);
    checkOutput("dropped_busy_len", lastBusyLen, 88);

    // Data_Valid held: exactly one idle clk between consecutive frames.
    @(posedge clk);
    #1;
    P_DATA     = 8'h55;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;
    Prescale   = 6'd4;
    Data_Valid = 1'b1;
    @(posedge clk);
    #1;
    P_DATA = 8'hAA;
    pushFrame(v55, 1);
    pushFrame(vAA, 3);
    repeat (60) @(negedge clk);
    Data_Valid = 1'b0;
    waitDrain("b2b_drain", 200);
    checkOutput("b2b_busy_len", lastBusyLen, 40);

    // Reset during data bit 3, then a clean frame.
    @(posedge clk);
    #1;
    P_DATA     = 8'hA5;
    PAR_EN     = 1'b1;
    PAR_TYP    = 1'b0;
    Prescale   = 6'd8;
    Data_Valid = 1'b1;
    @(posedge clk);
    #1;
    Data_Valid = 1'b0;
    pushFrame(vecs[0], 0);
    while (sbQueue.size() > 34) void'(sbQueue.pop_back());
    repeat (34) @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) sbQueue.push_back(exp_t'{1'b1, 1'b0});
    @(posedge clk);
    #1;
    rst = 1'b0;
    waitDrain("reset_mid_drain", 20);
    lastBusyLen = -1;
    applyStimulus(vecs[0], 2);
    waitDrain("post_reset_drain", 200);
    checkOutput("post_reset_busy_len", lastBusyLen, 88);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
